pc_seq: RTL

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_seq_npc_calc.sv | 35 +++
 rtl/pc_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared next-PC select codes, reset PC and FSM state encoding for the fetch sequencer.
package pc_seq_pkg;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_Br  = 3'd1;
    localparam logic [2:0] NPC_JAL = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_seq_npc_calc.sv
// Combinational redirect decode: flags a taken control transfer and computes its target.
module npc_calc
    import pc_seq_pkg::*;
(
    input  logic [2:0]  npc_op_i,
    input  logic        branch_i,
    input  logic [31:0] pc_d_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] ra_i,
    output logic        redir_o,
    output logic [31:0] tgt_o
);

    always_comb begin
        redir_o = 1'b0;
        tgt_o   = '0;
        case (npc_op_i)
            NPC_Br: begin
                redir_o = branch_i;
                tgt_o   = pc_d_i + 32'd4 + {{14{imm26_i[15]}}, imm26_i[15:0], 2'b00};
            end
            NPC_JAL: begin
                redir_o = 1'b1;
                tgt_o   = {pc_d_i[31:28], imm26_i, 2'b00};
            end
            NPC_JR: begin
                redir_o = 1'b1;
                tgt_o   = ra_i;
            end
            // Undefined codes fall through as sequential flow.
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage PC sequencer: BOOT/FETCH/HOLD FSM with a delay-slot pending redirect register.
// Define PC_SEQ_ALIGN_CHK_EN to add adel_f and skip fetching misaligned PCs.
module pc_seq
    import pc_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        branch,
    input  logic [31:0] pc_d,
    input  logic [25:0] imm26,
    input  logic [31:0] ra,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        im_req,
    output logic [31:0] im_addr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_f,
`ifdef PC_SEQ_ALIGN_CHK_EN
    output logic        valid_f,
    output logic        adel_f
`else
    output logic        valid_f
`endif
);

    state_e      state_q;
    logic [31:0] pc_f_q;
    logic [31:0] instr_f_q;
    logic        valid_f_q;
    logic        im_req_q;
    logic [31:0] im_addr_q;
    logic        pend_vld_q;
    logic [31:0] pend_tgt_q;
    logic        first_q;
`ifdef PC_SEQ_ALIGN_CHK_EN
    logic        adel_f_q;
`endif

    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc_next_d;

    npc_calc u_npc_calc (
        .npc_op_i (npc_op),
        .branch_i (branch),
        .pc_d_i   (pc_d),
        .imm26_i  (imm26),
        .ra_i     (ra),
        .redir_o  (redir),
        .tgt_o    (tgt)
    );

    // A live redirect beats an older pending one; both beat sequential flow.
    always_comb begin
        pc_next_d = pc_f_q + 32'd4;
        if (redir) begin
            pc_next_d = tgt;
        end else if (pend_vld_q) begin
            pc_next_d = pend_tgt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_f_q     <= RESET_PC;
            instr_f_q  <= '0;
            valid_f_q  <= 1'b0;
            im_req_q   <= 1'b0;
            im_addr_q  <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
            first_q    <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHK_EN
            adel_f_q   <= 1'b0;
`endif
        end else begin
            // Redirects seen while F is not advancing apply after the delay slot.
            if (state_q != StHold && !stall && redir) begin
                pend_vld_q <= 1'b1;
                pend_tgt_q <= tgt;
            end
            case (state_q)
                StBoot: begin
                    state_q   <= StFetch;
                    im_req_q  <= 1'b1;
                    im_addr_q <= word_align(pc_f_q);
                    first_q   <= 1'b1;
                end
                StFetch: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (im_ack) begin
                        instr_f_q <= im_rdata;
                        valid_f_q <= 1'b1;
                        im_req_q  <= 1'b0;
                        state_q   <= StHold;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        pc_f_q     <= pc_next_d;
                        valid_f_q  <= 1'b0;
                        pend_vld_q <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHK_EN
                        if (pc_next_d[1:0] != 2'b00) begin
                            adel_f_q  <= 1'b1;
                            instr_f_q <= '0;
                            valid_f_q <= 1'b1;
                        end else begin
                            adel_f_q  <= 1'b0;
                            state_q   <= StFetch;
                            im_req_q  <= 1'b1;
                            im_addr_q <= pc_next_d;
                            first_q   <= 1'b1;
                        end
`else
                        state_q   <= StFetch;
                        im_req_q  <= 1'b1;
                        im_addr_q <= word_align(pc_next_d);
                        first_q   <= 1'b1;
`endif
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign im_req  = im_req_q;
    assign im_addr = im_addr_q;
    assign pc_f    = pc_f_q;
    assign instr_f = instr_f_q;
    assign valid_f = valid_f_q;
`ifdef PC_SEQ_ALIGN_CHK_EN
    assign adel_f  = adel_f_q;
`endif

endmodule
